// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I pipeline: load-use interlock, branch flush,
// memory-stall freeze and same-cycle writeback bypass into the latched operands.

package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mem_byte_enable;
        logic [2:0]  aluop;
        logic        alu_imm;
    } rv32i_control_word;

endpackage

module id_ex_stage
    import rv32i_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  rv32i_word         id_instr,
    input  logic [31:0]       id_pc,
    input  rv32i_control_word id_ctrl,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  rv32i_control_word wb_ctrl,
    input  logic [31:0]       wb_data,
    input  logic              mem_stall,
    input  logic              br_flush,
    output logic              ex_valid,
    output rv32i_word         ex_instr,
    output logic [31:0]       ex_pc,
    output rv32i_control_word ex_ctrl,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_valid_reg, ex_valid_next;
    rv32i_word         ex_instr_reg, ex_instr_next;
    logic [31:0]       ex_pc_reg, ex_pc_next;
    rv32i_control_word ex_ctrl_reg, ex_ctrl_next;
    logic [31:0]       ex_rs1_reg, ex_rs1_next;
    logic [31:0]       ex_rs2_reg, ex_rs2_next;
    logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

    logic [4:0]  src_idx [2];
    logic [31:0] src_raw [2];
    logic [31:0] src_byp [2];
    logic        src_used [2];
    logic        src_hit [2];

    logic ex_load_pending;
    logic load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign src_idx[0] = id_instr[19:15];
    assign src_idx[1] = id_instr[24:20];
    assign src_raw[0] = id_rs1_data;
    assign src_raw[1] = id_rs2_data;

    // U/J-types read nothing; I-type-like opcodes read only rs1.
    assign src_used[0] = !(id_ctrl.opcode inside {op_lui, op_auipc, op_jal});
    assign src_used[1] = src_used[0] &&
                         !(id_ctrl.opcode inside {op_jalr, op_load, op_imm, op_csr});

    assign ex_load_pending = ex_valid_reg && (ex_ctrl_reg.opcode == op_load) &&
                             (ex_ctrl_reg.rd != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_idx[gi] == ex_ctrl_reg.rd);

            // x0 is hardwired; otherwise take the value being written back this cycle.
            assign src_byp[gi] = (src_idx[gi] == 5'd0) ? 32'd0 :
                                 (wb_ctrl.load_regfile && (wb_ctrl.rd != 5'd0) &&
                                  (wb_ctrl.rd == src_idx[gi])) ? wb_data : src_raw[gi];
        end
    endgenerate

    assign load_use = ex_load_pending && id_valid && (src_hit[0] || src_hit[1]);

    // A flush squashes the ID instruction, so it must not also hold IF/ID.
    assign stall_if_id = mem_stall || (!br_flush && load_use);

    always_comb begin
        ex_valid_next   = ex_valid_reg;
        ex_instr_next   = ex_instr_reg;
        ex_pc_next      = ex_pc_reg;
        ex_ctrl_next    = ex_ctrl_reg;
        ex_rs1_next     = ex_rs1_reg;
        ex_rs2_next     = ex_rs2_reg;
        bubble_cnt_next = bubble_cnt_reg;
        flush_cnt_next  = flush_cnt_reg;

        if (mem_stall) begin
            // Whole pipe frozen; flush and interlock are re-evaluated after release.
        end else if (br_flush) begin
            ex_valid_next  = 1'b0;
            ex_ctrl_next   = '0;
            flush_cnt_next = sat_inc(flush_cnt_reg);
        end else if (load_use) begin
            ex_valid_next   = 1'b0;
            ex_ctrl_next    = '0;
            bubble_cnt_next = sat_inc(bubble_cnt_reg);
        end else begin
            ex_valid_next = id_valid;
            ex_instr_next = id_instr;
            ex_pc_next    = id_pc;
            ex_ctrl_next  = id_valid ? id_ctrl : '0;
            ex_rs1_next   = src_byp[0];
            ex_rs2_next   = src_byp[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_instr_reg   <= '0;
            ex_pc_reg      <= '0;
            ex_ctrl_reg    <= '0;
            ex_rs1_reg     <= '0;
            ex_rs2_reg     <= '0;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            ex_instr_reg   <= ex_instr_next;
            ex_pc_reg      <= ex_pc_next;
            ex_ctrl_reg    <= ex_ctrl_next;
            ex_rs1_reg     <= ex_rs1_next;
            ex_rs2_reg     <= ex_rs2_next;
            bubble_cnt_reg <= bubble_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_instr    = ex_instr_reg;
    assign ex_pc       = ex_pc_reg;
    assign ex_ctrl     = ex_ctrl_reg;
    assign ex_rs1_data = ex_rs1_reg;
    assign ex_rs2_data = ex_rs2_reg;
    assign bubble_cnt  = bubble_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

endmodule
